// File: rtl/fifo_wide2narrow_param.sv
// Single-clock width-down FIFO: stores WR_WIDTH-bit words and reads them back as RATIO
// narrower lanes, with standard or first-word-fall-through read, occupancy counts and flags.
module fifo_wide2narrow_param #(
    parameter int unsigned WR_WIDTH   = 128,
    parameter int unsigned RATIO      = 2,
    parameter int unsigned DEPTH_LOG2 = 9,
    parameter int unsigned PF_THRESH  = 400,
    parameter int unsigned PE_THRESH  = 4,
    parameter bit          FWFT       = 1'b0,
    parameter bit          MSB_FIRST  = 1'b1,
    localparam int unsigned RD_W      = WR_WIDTH / RATIO,
    localparam int unsigned RCNT_W    = DEPTH_LOG2 + $clog2(RATIO) + 1
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  wr_en,
    input  logic [WR_WIDTH-1:0]   din,
    input  logic                  rd_en,
    output logic [RD_W-1:0]       dout,
    output logic                  valid,
    output logic                  full,
    output logic                  empty,
    output logic                  prog_full,
    output logic                  prog_empty,
    output logic [DEPTH_LOG2:0]   wr_count,
    output logic [RCNT_W-1:0]     rd_count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
    localparam int unsigned LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int unsigned CNT_W  = DEPTH_LOG2 + 1;

    logic [WR_WIDTH-1:0]   mem [DEPTH];

    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [LANE_W-1:0]     lane_idx_q, lane_idx_d;
    logic [CNT_W-1:0]      wr_count_q, wr_count_d;
    logic [RCNT_W-1:0]     rd_count_q, rd_count_d;
    logic                  prog_full_q, prog_empty_q;
    logic                  overflow_q, underflow_q;
    logic [WR_WIDTH-1:0]   head_word_q;
    logic [WR_WIDTH-1:0]   head_shift;
    logic [RD_W-1:0]       head_lane;
    int unsigned           shamt;
    logic                  wr_acc, rd_acc, word_free;
    logic                  full_w, empty_w;

    assign full_w  = (wr_count_q == CNT_W'(DEPTH));
    assign empty_w = (rd_count_q == '0);

    // Lane select from the registered head word; lane_idx counts in read order.
    always_comb begin
        shamt      = MSB_FIRST ? (RATIO - 1 - 32'(lane_idx_q)) * RD_W : 32'(lane_idx_q) * RD_W;
        head_shift = head_word_q >> shamt;
        head_lane  = head_shift[RD_W-1:0];
    end

    always_comb begin
        wr_acc     = wr_en & ~full_w;
        rd_acc     = rd_en & ~empty_w;
        word_free  = 1'b0;
        lane_idx_d = lane_idx_q;
        if (rd_acc) begin
            if (lane_idx_q == LANE_W'(RATIO - 1)) begin
                lane_idx_d = '0;
                word_free  = 1'b1;
            end else begin
                lane_idx_d = lane_idx_q + LANE_W'(1);
            end
        end

        wr_ptr_d = wr_acc    ? wr_ptr_q + DEPTH_LOG2'(1) : wr_ptr_q;
        rd_ptr_d = word_free ? rd_ptr_q + DEPTH_LOG2'(1) : rd_ptr_q;

        wr_count_d = wr_count_q;
        if (wr_acc && !word_free) begin
            wr_count_d = wr_count_q + CNT_W'(1);
        end else if (!wr_acc && word_free) begin
            wr_count_d = wr_count_q - CNT_W'(1);
        end

        rd_count_d = rd_count_q;
        if (wr_acc) begin
            rd_count_d = rd_count_d + RCNT_W'(RATIO);
        end
        if (rd_acc) begin
            rd_count_d = rd_count_d - RCNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            lane_idx_q   <= '0;
            wr_count_q   <= '0;
            rd_count_q   <= '0;
            prog_full_q  <= 1'b0;
            prog_empty_q <= 1'b1;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
            head_word_q  <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            lane_idx_q   <= lane_idx_d;
            wr_count_q   <= wr_count_d;
            rd_count_q   <= rd_count_d;
            prog_full_q  <= (wr_count_d >= CNT_W'(PF_THRESH));
            prog_empty_q <= (rd_count_d <= RCNT_W'(PE_THRESH));
            overflow_q   <= wr_en & full_w;
            underflow_q  <= rd_en & empty_w;
            // Registered RAM read at the next head address; forward din when it lands there.
            head_word_q  <= (wr_acc && (wr_ptr_q == rd_ptr_d)) ? din : mem[rd_ptr_d];
        end
    end

    generate
        if (FWFT) begin : g_fwft
            assign valid = ~empty_w;
            assign dout  = empty_w ? '0 : head_lane;
        end else begin : g_std
            logic            valid_q;
            logic [RD_W-1:0] dout_q;

            always_ff @(posedge clk or posedge srst) begin
                if (srst) begin
                    valid_q <= 1'b0;
                    dout_q  <= '0;
                end else begin
                    valid_q <= rd_acc;
                    if (rd_acc) begin
                        dout_q <= head_lane;
                    end
                end
            end

            assign valid = valid_q;
            assign dout  = dout_q;
        end
    endgenerate

    assign full       = full_w;
    assign empty      = empty_w;
    assign prog_full  = prog_full_q;
    assign prog_empty = prog_empty_q;
    assign wr_count   = wr_count_q;
    assign rd_count   = rd_count_q;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;

endmodule

// File: tb/tb_fifo_wide2narrow_param.sv
// Bench for fifo_wide2narrow_param: a standard-read 128->2x64 instance and an FWFT 128->4x32
// instance share stimulus and are compared every cycle against a lane-queue reference model.
module tb_fifo_wide2narrow_param;

    logic         clk;
    logic         srst;
    logic         wr_en;
    logic         rd_en;
    logic [127:0] din;

    logic [63:0] dout0;
    logic        valid0, full0, empty0, prog_full0, prog_empty0, overflow0, underflow0;
    logic [9:0]  wr_count0;
    logic [10:0] rd_count0;

    logic [31:0] dout1;
    logic        valid1, full1, empty1, prog_full1, prog_empty1, overflow1, underflow1;
    logic [4:0]  wr_count1;
    logic [6:0]  rd_count1;

    fifo_wide2narrow_param u_std (
        .clk        (clk),
        .srst       (srst),
        .wr_en      (wr_en),
        .din        (din),
        .rd_en      (rd_en),
        .dout       (dout0),
        .valid      (valid0),
        .full       (full0),
        .empty      (empty0),
        .prog_full  (prog_full0),
        .prog_empty (prog_empty0),
        .wr_count   (wr_count0),
        .rd_count   (rd_count0),
        .overflow   (overflow0),
        .underflow  (underflow0)
    );

    fifo_wide2narrow_param #(
        .WR_WIDTH   (128),
        .RATIO      (4),
        .DEPTH_LOG2 (4),
        .PF_THRESH  (12),
        .PE_THRESH  (4),
        .FWFT       (1'b1),
        .MSB_FIRST  (1'b1)
    ) u_fwft (
        .clk        (clk),
        .srst       (srst),
        .wr_en      (wr_en),
        .din        (din),
        .rd_en      (rd_en),
        .dout       (dout1),
        .valid      (valid1),
        .full       (full1),
        .empty      (empty1),
        .prog_full  (prog_full1),
        .prog_empty (prog_empty1),
        .wr_count   (wr_count1),
        .rd_count   (rd_count1),
        .overflow   (overflow1),
        .underflow  (underflow1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // DUT outputs gathered per instance; flags packed {valid,full,empty,pf,pe,ovf,unf}.
    logic [63:0] d_dout [2];
    logic [63:0] d_wrc  [2];
    logic [63:0] d_rdc  [2];
    logic [6:0]  d_flag [2];
    string       fname  [7] = '{"valid", "full", "empty", "prog_full", "prog_empty",
                                "overflow", "underflow"};

    always_comb begin
        d_dout[0] = 64'(dout0);
        d_dout[1] = 64'(dout1);
        d_wrc[0]  = 64'(wr_count0);
        d_wrc[1]  = 64'(wr_count1);
        d_rdc[0]  = 64'(rd_count0);
        d_rdc[1]  = 64'(rd_count1);
        d_flag[0] = {valid0, full0, empty0, prog_full0, prog_empty0, overflow0, underflow0};
        d_flag[1] = {valid1, full1, empty1, prog_full1, prog_empty1, overflow1, underflow1};
    end

    // Reference model: each instance is a queue of lanes held in a circular array.
    function automatic int ratio_of(int m);  return (m == 0) ? 2 : 4;     endfunction
    function automatic int depth_of(int m);  return (m == 0) ? 512 : 16;  endfunction
    function automatic int pf_of(int m);     return (m == 0) ? 400 : 12;  endfunction
    function automatic int pe_of(int m);     return 4;                    endfunction
    function automatic bit fwft_of(int m);   return m == 1;               endfunction

    logic [63:0] m_buf [2][1024];
    int          m_head [2];
    int          m_cnt  [2];
    logic [63:0] m_dout [2];
    logic        m_valid[2];
    logic        m_ovf  [2];
    logic        m_unf  [2];

    function automatic logic [63:0] lane_of(int m, logic [127:0] d, int k);
        int           w;
        logic [127:0] t;
        w = 128 / ratio_of(m);
        t = d >> (128 - (k + 1) * w);
        t = t & ((128'(1) << w) - 128'(1));
        return t[63:0];
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_head[m]  = 0;
            m_cnt[m]   = 0;
            m_dout[m]  = '0;
            m_valid[m] = 1'b0;
            m_ovf[m]   = 1'b0;
            m_unf[m]   = 1'b0;
        end
    endtask

    task automatic model_step(input logic w, input logic r, input logic [127:0] d);
        for (int m = 0; m < 2; m++) begin
            int  words;
            bit  is_full, is_empty;
            words    = (m_cnt[m] + ratio_of(m) - 1) / ratio_of(m);
            is_full  = (words == depth_of(m));
            is_empty = (m_cnt[m] == 0);
            m_ovf[m] = w && is_full;
            m_unf[m] = r && is_empty;
            m_valid[m] = r && !is_empty;
            if (r && !is_empty) begin
                m_dout[m] = m_buf[m][m_head[m]];
                m_head[m] = (m_head[m] + 1) % 1024;
                m_cnt[m]--;
            end
            if (w && !is_full) begin
                for (int k = 0; k < ratio_of(m); k++) begin
                    m_buf[m][(m_head[m] + m_cnt[m]) % 1024] = lane_of(m, d, k);
                    m_cnt[m]++;
                end
            end
        end
    endtask

    task automatic compare_all(input string ph);
        for (int m = 0; m < 2; m++) begin
            int          words;
            logic [6:0]  ef;
            logic [63:0] ed;
            bit          ev;
            words = (m_cnt[m] + ratio_of(m) - 1) / ratio_of(m);
            ev    = fwft_of(m) ? (m_cnt[m] != 0) : m_valid[m];
            if (fwft_of(m)) begin
                ed = (m_cnt[m] != 0) ? m_buf[m][m_head[m]] : 64'h0;
            end else begin
                ed = m_dout[m];
            end
            ef = {ev, words == depth_of(m), m_cnt[m] == 0, words >= pf_of(m),
                  m_cnt[m] <= pe_of(m), m_ovf[m], m_unf[m]};
            check($sformatf("%s.m%0d.dout", ph, m), d_dout[m], ed);
            check($sformatf("%s.m%0d.wr_count", ph, m), d_wrc[m], 64'(words));
            check($sformatf("%s.m%0d.rd_count", ph, m), d_rdc[m], 64'(m_cnt[m]));
            for (int i = 0; i < 7; i++) begin
                check($sformatf("%s.m%0d.%s", ph, m, fname[i]), 64'(d_flag[m][6-i]),
                      64'(ef[6-i]));
            end
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Inputs change at the falling edge; the model advances at the rising edge.
    task automatic step(input logic w, input logic r, input logic [127:0] d, input string ph);
        wr_en = w;
        rd_en = r;
        din   = d;
        @(posedge clk);
        model_step(w, r, d);
        @(negedge clk);
        compare_all(ph);
    endtask

    initial begin
        srst  = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        din   = '0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all("reset");
        srst = 1'b0;

        // Single word read back lane by lane, upper half first.
        step(1'b1, 1'b0, {64'h0000_0000_0000_0001, 64'h0}, "t1");
        step(1'b0, 1'b1, '0, "t1");
        step(1'b0, 1'b1, '0, "t1");
        repeat (4) step(1'b0, 1'b1, '0, "t1drain");

        // Fill past capacity, then drain and let the model confirm contents.
        repeat (513) step(1'b1, 1'b0, rnd128(), "t2fill");
        step(1'b0, 1'b0, '0, "t2idle");
        repeat (1030) step(1'b0, 1'b1, '0, "t2drain");

        // Underflow alone and alongside the first write.
        step(1'b0, 1'b1, '0, "t3");
        step(1'b1, 1'b1, rnd128(), "t3");
        step(1'b0, 1'b0, '0, "t3");
        repeat (5) step(1'b0, 1'b1, '0, "t3drain");

        // Simultaneous read/write on a full FIFO.
        repeat (512) step(1'b1, 1'b0, rnd128(), "t4fill");
        repeat (2048) step(1'b1, 1'b1, rnd128(), "t4");
        repeat (1030) step(1'b0, 1'b1, '0, "t4drain");

        // One word popped lane by lane (FWFT instance drains in four pops).
        step(1'b1, 1'b0, rnd128(), "t5");
        repeat (5) step(1'b0, 1'b1, '0, "t5");

        // Random traffic at several write/read mixes.
        for (int p = 0; p < 3; p++) begin
            int wp, rp;
            wp = 70 - 20 * p;
            rp = 30 + 25 * p;
            repeat (600) begin
                logic w, r;
                w = ($urandom_range(0, 99) < wp);
                r = ($urandom_range(0, 99) < rp);
                step(w, r, rnd128(), "rand");
            end
        end

        // Asynchronous reset mid-transfer with reads requested.
        repeat (300) step(1'b1, 1'b0, rnd128(), "t6fill");
        wr_en = 1'b0;
        rd_en = 1'b1;
        #2;
        srst = 1'b1;
        #1;
        model_reset();
        compare_all("t6async");
        @(posedge clk);
        @(negedge clk);
        compare_all("t6hold");
        srst = 1'b0;
        step(1'b1, 1'b0, {64'hDEAD_BEEF_0123_4567, 64'hCAFE_F00D_89AB_CDEF}, "t6");
        repeat (5) step(1'b0, 1'b1, '0, "t6");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
